dht_sensor_emu: RTL and testbench
=================================

# dht_sensor_emu

Synthesizable single-wire humidity/temperature sensor emulator, the parametrised successor to our behavioural DHT11 model. Detects a host start request on an open-drain line, answers with the response preamble, then transmits a 32-bit payload plus 8-bit checksum using pulse-width encoding. Timing is in microseconds via a clock prescaler, so one RTL serves DHT11 and DHT22-class timing. Sits on the bench side of host-controller tests and in FPGA loop-back rigs.

## Interface
- CLK_PER_US, 4: clk cycles per µs tick (≥2)
- REQ_LOW_MIN_US, 18000: minimum host low to accept a request (1000 for DHT22 class)
- RESP_DELAY_US, 30: host-release-to-response delay
- RESP_LOW_US, 80 / RESP_HIGH_US, 80: response preamble phases
- BIT_LOW_US, 50: low lead-in of every bit and of the tail
- BIT0_HIGH_US, 26 / BIT1_HIGH_US, 70: high time for 0 / 1
- REL_TIMEOUT_US, 200: max wait for host release after a valid request
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- data_i  in  1  line level (asynchronous, pulled up)
- data_oe  out  1  1 = drive line low; 0 = release (open-drain)
- payload_i  in  32  {hum_int, hum_dec, temp_int, temp_dec}
- payload_valid  in  1  write payload_i to shadow register
- payload_ready  out  1  constant 1 out of reset
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse after tail release
- abort  out  1  one-cycle pulse on contention abort

## Operation
- data_i double-flop synchronised; all decisions use synchronised value.
- Shadow payload written on payload_valid && payload_ready any cycle; reset value 32'h0.
- Snapshot: on entering RESP_LOW, frame register ← {shadow, checksum}, checksum = (sum of 4 bytes) mod 256. Write in the same cycle as snapshot: frame takes old shadow; new value used next frame.
- Transmission MSB first, bit 39 to bit 0.
- States: IDLE → REQ_LOW on synced falling edge. REQ_LOW counts µs; release before REQ_LOW_MIN_US → IDLE (no response); reaching min → REQ_WAIT. REQ_WAIT: release → RESP_DELAY; REL_TIMEOUT_US elapsed with line still low → IDLE. RESP_DELAY (RESP_DELAY_US) → RESP_LOW (oe=1) → RESP_HIGH (oe=0) → BIT_LOW (oe=1, BIT_LOW_US) → BIT_HIGH (oe=0, BIT0/BIT1_HIGH_US per bit) → next BIT_LOW or, after bit 0, TAIL (oe=1, BIT_LOW_US) → IDLE with frame_done.
- Contention: in RESP_HIGH or BIT_HIGH, synced line low on 2 consecutive µs ticks → oe=0, abort pulse, IDLE.
- Host activity outside REQ states and contention windows ignored.

## Timing
- Reset: data_oe=0, busy=0, frame_done=0, abort=0, payload_ready=1, state IDLE, prescaler and counters 0; applies asynchronously, mid-frame included (line released immediately).
- µs counter width = $clog2(max of all µs params + 1); prescaler width $clog2(CLK_PER_US).
- Prescaler restarts on every state change, so each phase lasts exactly N·CLK_PER_US cycles.
- data_oe registered; changes one clk after the state transition cycle. Input-to-detection latency: 2 clk synchroniser + 1 clk.
- busy rises the cycle after falling edge detection; falls with the frame_done/abort cycle.

## Structure
- Package dht_pkg: state enum, default timing constants for DHT11 and DHT22 presets, checksum function.
- Sub-module dht_us_tick: prescaler with clear input, emits one-cycle tick every CLK_PER_US cycles.

## Test plan
- CLK_PER_US=4, payload 32'h3700_1A05 written, host low 18 ms, release → oe low 30 µs later for 80 µs, high 80 µs, 40 bits MSB first, checksum 8'h56, tail 50 µs, frame_done once.
- Host low 10 ms then release → data_oe never asserts, busy returns 0, no frame_done.
- payload_valid in snapshot cycle with 32'hFFFF_FFFF → current frame carries old payload; next frame carries FF…FF, checksum 8'hFC.
- Host forces line low 3 µs during a BIT_HIGH → abort pulse, oe=0, state IDLE; new request then served normally.
- rst_n asserted mid-BIT_LOW → data_oe=0 in same cycle (async); after release, full frame on next request.
- REQ_LOW_MIN_US=1000 (DHT22 preset), host low 1.1 ms → response follows; 0.9 ms → ignored.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types, timing presets and checksum helper for the single-wire
// humidity/temperature sensor emulator.
package dht_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ_LOW,
      ST_REQ_WAIT,
      ST_RESP_DELAY,
      ST_RESP_LOW,
      ST_RESP_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_TAIL
   } dht_state_t;

   localparam int unsigned DHT_FRAME_BITS       = 40;

   // DHT11-class timing; DHT22-class parts only shorten the start request.
   localparam int unsigned DHT11_REQ_LOW_MIN_US = 18000;
   localparam int unsigned DHT22_REQ_LOW_MIN_US = 1000;
   localparam int unsigned DHT_RESP_DELAY_US    = 30;
   localparam int unsigned DHT_RESP_LOW_US      = 80;
   localparam int unsigned DHT_RESP_HIGH_US     = 80;
   localparam int unsigned DHT_BIT_LOW_US       = 50;
   localparam int unsigned DHT_BIT0_HIGH_US     = 26;
   localparam int unsigned DHT_BIT1_HIGH_US     = 70;
   localparam int unsigned DHT_REL_TIMEOUT_US   = 200;

   function automatic logic [7:0] dht_checksum(input logic [31:0] p);
      return p[31:24] + p[23:16] + p[15:8] + p[7:0];
   endfunction

   function automatic int unsigned dht_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable
// so that every protocol phase begins on a fresh microsecond boundary.
module dht_us_tick #(
   parameter int unsigned CLK_PER_US = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = $clog2(CLK_PER_US);
   localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/dht_sensor_emu.sv
// Single-wire sensor emulator: accepts a host start request, answers with the
// response preamble and sends {payload, checksum} MSB first, pulse-width coded.
module dht_sensor_emu
   import dht_pkg::*;
#(
   parameter int unsigned CLK_PER_US     = 4,
   parameter int unsigned REQ_LOW_MIN_US = DHT11_REQ_LOW_MIN_US,
   parameter int unsigned RESP_DELAY_US  = DHT_RESP_DELAY_US,
   parameter int unsigned RESP_LOW_US    = DHT_RESP_LOW_US,
   parameter int unsigned RESP_HIGH_US   = DHT_RESP_HIGH_US,
   parameter int unsigned BIT_LOW_US     = DHT_BIT_LOW_US,
   parameter int unsigned BIT0_HIGH_US   = DHT_BIT0_HIGH_US,
   parameter int unsigned BIT1_HIGH_US   = DHT_BIT1_HIGH_US,
   parameter int unsigned REL_TIMEOUT_US = DHT_REL_TIMEOUT_US
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_i,
   output logic        data_oe,
   input  logic [31:0] payload_i,
   input  logic        payload_valid,
   output logic        payload_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        abort
);

   localparam int unsigned US_MAX = dht_max(
      dht_max(dht_max(REQ_LOW_MIN_US, RESP_DELAY_US), dht_max(RESP_LOW_US, RESP_HIGH_US)),
      dht_max(dht_max(BIT_LOW_US, BIT0_HIGH_US), dht_max(BIT1_HIGH_US, REL_TIMEOUT_US)));
   localparam int unsigned UW = $clog2(US_MAX + 1);
   localparam logic [5:0] FIRST_BIT = 6'(DHT_FRAME_BITS - 1);

   typedef logic [UW-1:0] us_t;

   dht_state_t  state, state_next;
   logic        sync1, line, line_prev, fall;
   logic        tick, state_chg, phase_end;
   us_t         us_cnt, phase_len;
   logic        lo_seen, contention;
   logic [31:0] shadow;
   logic [39:0] frame;
   logic [5:0]  bit_idx;
   logic        snapshot, bit_step;
   logic        oe_d, done_d, abort_d;

   assign payload_ready = 1'b1;

   // Synchroniser resets to the pulled-up level so reset release never looks like a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         line      <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync1     <= data_i;
         line      <= sync1;
         line_prev <= line;
      end
   end

   assign fall      = line_prev & ~line;
   assign state_chg = (state_next != state);

   dht_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_chg),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt  <= '0;
         lo_seen <= 1'b0;
      end else if (state_chg) begin
         us_cnt  <= '0;
         lo_seen <= 1'b0;
      end else if (tick) begin
         us_cnt  <= us_cnt + 1'b1;
         lo_seen <= ~line;
      end
   end

   always_comb begin
      phase_len = '0;
      case (state)
         ST_REQ_LOW:    phase_len = us_t'(REQ_LOW_MIN_US - 1);
         ST_REQ_WAIT:   phase_len = us_t'(REL_TIMEOUT_US - 1);
         ST_RESP_DELAY: phase_len = us_t'(RESP_DELAY_US - 1);
         ST_RESP_LOW:   phase_len = us_t'(RESP_LOW_US - 1);
         ST_RESP_HIGH:  phase_len = us_t'(RESP_HIGH_US - 1);
         ST_BIT_LOW,
         ST_TAIL:       phase_len = us_t'(BIT_LOW_US - 1);
         ST_BIT_HIGH:   phase_len = frame[bit_idx] ? us_t'(BIT1_HIGH_US - 1)
                                                   : us_t'(BIT0_HIGH_US - 1);
         default:       phase_len = '0;
      endcase
   end

   assign phase_end  = tick && (us_cnt == phase_len);
   assign contention = (state == ST_RESP_HIGH || state == ST_BIT_HIGH) && tick && !line && lo_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         data_oe    <= 1'b0;
         frame_done <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state      <= state_next;
         data_oe    <= oe_d;
         frame_done <= done_d;
         abort      <= abort_d;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:       if (fall) state_next = ST_REQ_LOW;
         ST_REQ_LOW:    if (line) state_next = ST_IDLE;
                        else if (phase_end) state_next = ST_REQ_WAIT;
         ST_REQ_WAIT:   if (line) state_next = ST_RESP_DELAY;
                        else if (phase_end) state_next = ST_IDLE;
         ST_RESP_DELAY: if (phase_end) state_next = ST_RESP_LOW;
         ST_RESP_LOW:   if (phase_end) state_next = ST_RESP_HIGH;
         ST_RESP_HIGH:  if (contention) state_next = ST_IDLE;
                        else if (phase_end) state_next = ST_BIT_LOW;
         ST_BIT_LOW:    if (phase_end) state_next = ST_BIT_HIGH;
         ST_BIT_HIGH:   if (contention) state_next = ST_IDLE;
                        else if (phase_end) state_next = (bit_idx == '0) ? ST_TAIL : ST_BIT_LOW;
         ST_TAIL:       if (phase_end) state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they move on the transition edge.
   always_comb begin
      oe_d = 1'b0;
      case (state_next)
         ST_RESP_LOW, ST_BIT_LOW, ST_TAIL: oe_d = 1'b1;
         default:                          oe_d = 1'b0;
      endcase
      done_d  = (state == ST_TAIL) && (state_next == ST_IDLE);
      abort_d = contention;
      busy    = (state != ST_IDLE);
   end

   assign snapshot = (state == ST_RESP_DELAY) && (state_next == ST_RESP_LOW);
   assign bit_step = (state == ST_BIT_HIGH) && (state_next == ST_BIT_LOW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         frame   <= '0;
         bit_idx <= '0;
      end else begin
         if (payload_valid && payload_ready) shadow <= payload_i;
         if (snapshot) begin
            frame   <= {shadow, dht_checksum(shadow)};
            bit_idx <= FIRST_BIT;
         end else if (bit_step) begin
            bit_idx <= bit_idx - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dht_sensor_emu.sv
// Directed/randomised bench for dht_sensor_emu: measures line pulse widths and
// decodes frames, comparing against the protocol rules with scaled timing.
module tb_dht_sensor_emu;
   import dht_pkg::*;

   localparam int C   = 4;
   localparam int MIN = 100;
   localparam int TO  = 40;
   localparam int DLY = 6;
   localparam int RL  = 16;
   localparam int RH  = 16;
   localparam int BL  = 10;
   localparam int B0  = 5;
   localparam int B1  = 14;
   localparam int LIM = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst_b, host_low, host_low_b;
   logic        line_a, line_b;
   logic        data_oe, data_oe_b;
   logic [31:0] payload, payload_b;
   logic        payload_valid, payload_valid_b;
   logic        payload_ready, busy, frame_done, abort;
   logic        payload_ready_b, busy_b, frame_done_b, abort_b;

   assign line_a = ~(data_oe | host_low);
   assign line_b = ~(data_oe_b | host_low_b);

   dht_sensor_emu #(
      .CLK_PER_US(C), .REQ_LOW_MIN_US(MIN), .RESP_DELAY_US(DLY), .RESP_LOW_US(RL),
      .RESP_HIGH_US(RH), .BIT_LOW_US(BL), .BIT0_HIGH_US(B0), .BIT1_HIGH_US(B1),
      .REL_TIMEOUT_US(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_i(line_a), .data_oe(data_oe),
      .payload_i(payload), .payload_valid(payload_valid), .payload_ready(payload_ready),
      .busy(busy), .frame_done(frame_done), .abort(abort)
   );

   dht_sensor_emu #(.CLK_PER_US(C), .REQ_LOW_MIN_US(DHT22_REQ_LOW_MIN_US)) dut_b (
      .clk(clk), .rst_n(rst_b), .data_i(line_b), .data_oe(data_oe_b),
      .payload_i(payload_b), .payload_valid(payload_valid_b), .payload_ready(payload_ready_b),
      .busy(busy_b), .frame_done(frame_done_b), .abort(abort_b)
   );

   int checks = 0, passed = 0, fails = 0;
   int fd_cnt = 0, ab_cnt = 0;
   logic [31:0] model_shadow = '0;

   always @(posedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (abort === 1'b1) ab_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_payload(input logic [31:0] v);
      payload = v;
      payload_valid = 1'b1;
      @(negedge clk);
      payload_valid = 1'b0;
      model_shadow = v;
   endtask

   task automatic wait_oe(input logic lvl, output int n);
      n = 0;
      while (data_oe !== lvl && n < LIM) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Host start request: hold line low for us microseconds, busy is checked just before release.
   task automatic request(input int us, input logic exp_busy, input string tag);
      host_low = 1'b1;
      cycles(us * C);
      check(tag, busy, exp_busy);
      host_low = 1'b0;
   endtask

   task automatic capture_frame(input logic [31:0] exp_pay, input logic inject,
                                input logic [31:0] inj_val);
      int n, lo, hi, t_err, fd0, ab0;
      logic [39:0] rx;
      logic [7:0]  exp_ck;
      fd0 = fd_cnt;
      ab0 = ab_cnt;
      exp_ck = 8'((exp_pay >> 24) + ((exp_pay >> 16) & 32'hFF) + ((exp_pay >> 8) & 32'hFF)
                  + (exp_pay & 32'hFF));
      n = 0;
      while (data_oe !== 1'b1 && n < LIM) begin
         if (inject && n == DLY * C + 2) begin
            payload = inj_val;
            payload_valid = 1'b1;
         end
         @(negedge clk);
         n++;
         payload_valid = 1'b0;
      end
      check("resp_delay", n, DLY * C + 3);
      if (n >= LIM) return;
      wait_oe(1'b0, lo);
      check("resp_low", lo, RL * C);
      wait_oe(1'b1, hi);
      check("resp_high", hi, RH * C);
      t_err = 0;
      rx = '0;
      for (int i = 39; i >= 0; i--) begin
         wait_oe(1'b0, lo);
         wait_oe(1'b1, hi);
         rx[i] = (hi > (B0 + B1) * C / 2);
         if (lo != BL * C || hi != (rx[i] ? B1 : B0) * C) t_err++;
         if (hi >= LIM) break;
      end
      check("bit_timing_errors", t_err, 0);
      check("payload", rx[39:8], exp_pay);
      check("checksum", rx[7:0], exp_ck);
      wait_oe(1'b0, lo);
      check("tail_low", lo, BL * C);
      check("busy_after_frame", busy, 1'b0);
      cycles(3);
      check("frame_done_once", fd_cnt - fd0, 1);
      check("no_abort_in_frame", ab_cnt - ab0, 0);
   endtask

   task automatic expect_silence(input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < (DLY + RL) * C + 40; i++) begin
         @(negedge clk);
         if (data_oe !== 1'b0) seen++;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      int n, lo, hi, k, fd0, ab0, got;
      logic oe_ab, busy_ab;
      logic [31:0] v;

      rst_n = 1'b0; rst_b = 1'b0; host_low = 1'b0; host_low_b = 1'b0;
      payload = '0; payload_valid = 1'b0; payload_b = '0; payload_valid_b = 1'b0;
      cycles(3);
      check("rst_data_oe", data_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_abort", abort, 1'b0);
      check("rst_payload_ready", payload_ready, 1'b1);
      rst_n = 1'b1; rst_b = 1'b1;
      cycles(3);

      // Reference payload from the bring-up note: checksum 8'h56.
      write_payload(32'h3700_1A05);
      request(MIN + $urandom_range(5, 25), 1'b1, "busy_req_ok");
      capture_frame(model_shadow, 1'b0, '0);

      // Short request: ignored.
      fd0 = fd_cnt;
      request($urandom_range(20, MIN - 10), 1'b1, "busy_short_req");
      expect_silence("short_req_no_oe");
      check("short_req_idle", busy, 1'b0);
      check("short_req_no_done", fd_cnt - fd0, 0);

      // Host never releases within the timeout: back to idle, then release ignored.
      request(MIN + TO + 20, 1'b0, "busy_after_timeout");
      expect_silence("timeout_no_oe");
      check("timeout_no_done", fd_cnt - fd0, 0);

      for (int r = 0; r < 2; r++) begin
         write_payload($urandom);
         cycles(4);
         request(MIN + $urandom_range(5, 30), 1'b1, "busy_req_rand");
         capture_frame(model_shadow, 1'b0, '0);
      end

      // Write landing in the snapshot cycle belongs to the following frame.
      request(MIN + 10, 1'b1, "busy_req_snap");
      capture_frame(model_shadow, 1'b1, 32'hFFFF_FFFF);
      model_shadow = 32'hFFFF_FFFF;
      request(MIN + 10, 1'b1, "busy_req_after_snap");
      capture_frame(model_shadow, 1'b0, '0);

      // Contention in a BIT_HIGH phase.
      write_payload($urandom);
      request(MIN + 12, 1'b1, "busy_req_cont");
      fd0 = fd_cnt;
      ab0 = ab_cnt;
      wait_oe(1'b1, n);
      wait_oe(1'b0, lo);
      wait_oe(1'b1, hi);
      k = $urandom_range(3, 30);
      for (int j = 0; j < k; j++) begin
         wait_oe(1'b0, lo);
         wait_oe(1'b1, hi);
      end
      wait_oe(1'b0, lo);
      host_low = 1'b1;
      got = 0;
      oe_ab = 1'bx;
      busy_ab = 1'bx;
      for (int i = 0; i < 3 * C; i++) begin
         @(negedge clk);
         if (abort === 1'b1 && got == 0) begin
            got = 1;
            oe_ab = data_oe;
            busy_ab = busy;
         end
      end
      host_low = 1'b0;
      check("abort_seen", got, 1);
      check("abort_oe_released", oe_ab, 1'b0);
      check("abort_idle", busy_ab, 1'b0);
      cycles(3);
      check("abort_single_pulse", ab_cnt - ab0, 1);
      check("abort_no_done", fd_cnt - fd0, 0);
      cycles(20 * C);
      request(MIN + 15, 1'b1, "busy_req_after_abort");
      capture_frame(model_shadow, 1'b0, '0);

      // Asynchronous reset in the middle of a BIT_LOW.
      write_payload($urandom);
      request(MIN + 8, 1'b1, "busy_req_rst");
      wait_oe(1'b1, n);
      wait_oe(1'b0, lo);
      wait_oe(1'b1, hi);
      cycles(5);
      check("pre_reset_oe", data_oe, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_oe", data_oe, 1'b0);
      check("async_reset_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_shadow = '0;
      cycles(10);
      request(MIN + 20, 1'b1, "busy_req_post_rst");
      capture_frame(model_shadow, 1'b0, '0);

      // DHT22 preset instance: 0.9 ms ignored, 1.1 ms answered.
      host_low_b = 1'b1;
      cycles(900 * C);
      host_low_b = 1'b0;
      n = 0;
      for (int i = 0; i < (DHT_RESP_DELAY_US + 10) * C; i++) begin
         @(negedge clk);
         if (data_oe_b !== 1'b0) n++;
      end
      check("dht22_short_no_oe", n, 0);
      check("dht22_short_idle", busy_b, 1'b0);
      host_low_b = 1'b1;
      cycles(1100 * C);
      host_low_b = 1'b0;
      n = 0;
      while (data_oe_b !== 1'b1 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      check("dht22_resp_delay", n, DHT_RESP_DELAY_US * C + 3);
      rst_b = 1'b0;
      cycles(2);
      rst_b = 1'b1;

      v = model_shadow;
      check("model_shadow_zero_after_reset", v, 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
